// File: rtl/capture_ctrl.sv
// capture_ctrl: circular-buffer capture FSM with pre-trigger history and post-trigger count
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2 = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            wrt_smpl,
  input  logic            triggered,
  input  logic [LOG2-1:0] trig_pos,
  output logic            we,
  output logic [LOG2-1:0] waddr,
  output logic            armed,
  output logic            set_capture_done,
  output logic [LOG2-1:0] addr_ptr,
  output logic            capturing
);
  localparam logic [2:0] IDLE = 3'd0, PRE = 3'd1, ARMED = 3'd2, POST = 3'd3, DONE = 3'd4;
  localparam logic [LOG2:0] ENT = (LOG2+1)'(ENTRIES);
  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);
  logic [2:0] state, state_nxt;
  logic [LOG2:0] smpl_cnt, smpl_nxt, thr;
  logic [LOG2-1:0] post_cnt, post_nxt, tp, waddr_nxt;
  logic finish;
  assign tp = trig_pos == '0 ? LOG2'(1) : ({1'b0, trig_pos} >= ENT ? LAST : trig_pos);
  assign thr = ENT - {1'b0, tp};
  assign capturing = state == PRE || state == ARMED || state == POST;
  assign we = wrt_smpl & capturing & ~rst;
  assign waddr_nxt = we ? (waddr == LAST ? '0 : waddr + LOG2'(1)) : waddr;
  assign smpl_nxt = we && smpl_cnt != ENT ? smpl_cnt + (LOG2+1)'(1) : smpl_cnt;
  assign post_nxt = we && state == POST ? post_cnt + LOG2'(1) : post_cnt;
  assign finish = state == POST && state_nxt == DONE;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = run ? PRE : IDLE;
      PRE:     state_nxt = !run ? IDLE : (smpl_nxt >= thr ? ARMED : PRE);
      ARMED:   state_nxt = !run ? IDLE : (triggered ? POST : ARMED);
      POST:    state_nxt = !run ? IDLE : (post_nxt >= tp ? DONE : POST);
      DONE:    state_nxt = run ? DONE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      waddr <= '0;
      smpl_cnt <= '0;
      post_cnt <= '0;
      addr_ptr <= '0;
      armed <= 1'b0;
      set_capture_done <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= state_nxt == ARMED;
      set_capture_done <= finish;
      waddr <= state == IDLE && run ? '0 : waddr_nxt;
      smpl_cnt <= state == IDLE && run ? '0 : smpl_nxt;
      post_cnt <= state == IDLE && run ? '0 : post_nxt;
      if (finish) addr_ptr <= waddr_nxt;
    end
  end
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed tests of capture_ctrl with hand-computed expectations
module tb_capture_ctrl;
  localparam int ENTRIES = 384;
  localparam int LOG2 = 9;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, wrt_smpl = 1'b0, triggered = 1'b0;
  logic [LOG2-1:0] trig_pos = '0;
  logic we, armed, set_capture_done, capturing;
  logic [LOG2-1:0] waddr, addr_ptr;
  int total = 0, bad = 0, we_cnt = 0, done_cnt = 0;
  capture_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk(clk), .rst(rst), .run(run), .wrt_smpl(wrt_smpl), .triggered(triggered),
    .trig_pos(trig_pos), .we(we), .waddr(waddr), .armed(armed),
    .set_capture_done(set_capture_done), .addr_ptr(addr_ptr), .capturing(capturing)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (we) we_cnt++;
    if (set_capture_done) done_cnt++;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr();
    wrt_smpl = 1'b1;
    tick();
    wrt_smpl = 1'b0;
    repeat (3) tick();
  endtask
  task automatic start(input int tpv);
    run = 1'b0;
    tick();
    trig_pos = LOG2'(tpv);
    run = 1'b1;
    tick();
  endtask
  task automatic arm_count(output int n);
    n = 0;
    while (!armed && n < ENTRIES + 20) begin
      wr();
      n++;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    total++; if ({we, armed, set_capture_done, capturing, waddr, addr_ptr} !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", {we, armed, set_capture_done, capturing, waddr, addr_ptr}); end
  endtask
  task automatic test_pre_arm();
    int n, d0;
    start(100);
    d0 = done_cnt;
    total++; if (capturing !== 1'b1) begin bad++; $display("FAIL pre_capturing: got %b want 1", capturing); end
    arm_count(n);
    total++; if (n !== 284) begin bad++; $display("FAIL pre_arm_writes: got %0d want 284", n); end
    total++; if (waddr !== 9'd284) begin bad++; $display("FAIL pre_waddr: got %0d want 284", waddr); end
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL pre_no_done: got %0d want %0d", done_cnt, d0); end
  endtask
  task automatic test_post();
    int n, d0, w0;
    w0 = we_cnt;
    d0 = done_cnt;
    triggered = 1'b1;
    tick();
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      wr();
      n++;
    end
    total++; if (we_cnt - w0 !== 100) begin bad++; $display("FAIL post_we_pulses: got %0d want 100", we_cnt - w0); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL post_done_pulses: got %0d want 1", done_cnt - d0); end
    total++; if (waddr !== 9'd0) begin bad++; $display("FAIL post_waddr: got %0d want 0", waddr); end
    total++; if (addr_ptr !== 9'd0) begin bad++; $display("FAIL post_addr_ptr: got %0d want 0", addr_ptr); end
    total++; if ({armed, capturing} !== 2'b00) begin bad++; $display("FAIL post_done_state: got %b want 00", {armed, capturing}); end
    w0 = we_cnt;
    repeat (3) wr();
    total++; if (we_cnt !== w0 || waddr !== 9'd0) begin bad++; $display("FAIL done_no_write: got we=%0d waddr=%0d want we=%0d waddr=0", we_cnt, waddr, w0); end
    run = 1'b0;
    triggered = 1'b0;
    tick();
  endtask
  task automatic test_wrap();
    int d0;
    start(50);
    for (int i = 1; i <= 500; i++) begin
      wr();
      if (i == 383) begin total++; if (waddr !== 9'd383) begin bad++; $display("FAIL wrap_383: got %0d want 383", waddr); end end
      if (i == 384) begin total++; if (waddr !== 9'd0) begin bad++; $display("FAIL wrap_0: got %0d want 0", waddr); end end
    end
    total++; if (waddr !== 9'd116 || armed !== 1'b1) begin bad++; $display("FAIL wrap_armed: got waddr=%0d armed=%b want 116 1", waddr, armed); end
    d0 = done_cnt;
    triggered = 1'b1;
    tick();
    repeat (50) wr();
    total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL wrap_done: got %0d want %0d", done_cnt, d0 + 1); end
    total++; if (addr_ptr !== 9'd166) begin bad++; $display("FAIL wrap_addr_ptr: got %0d want 166", addr_ptr); end
    run = 1'b0;
    triggered = 1'b0;
    tick();
  endtask
  task automatic test_abort();
    int n, d0;
    start(100);
    arm_count(n);
    triggered = 1'b1;
    tick();
    repeat (10) wr();
    d0 = done_cnt;
    run = 1'b0;
    tick();
    total++; if ({armed, capturing} !== 2'b00) begin bad++; $display("FAIL abort_idle: got %b want 00", {armed, capturing}); end
    total++; if (waddr !== 9'd294 || addr_ptr !== 9'd166) begin bad++; $display("FAIL abort_kept: got waddr=%0d ptr=%0d want 294 166", waddr, addr_ptr); end
    repeat (4) tick();
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL abort_no_done: got %0d want %0d", done_cnt, d0); end
    triggered = 1'b0;
  endtask
  task automatic test_boundary();
    int n, d0;
    start(0);
    arm_count(n);
    total++; if (n !== 383) begin bad++; $display("FAIL tp0_arm_writes: got %0d want 383", n); end
    d0 = done_cnt;
    triggered = 1'b1;
    tick();
    wr();
    total++; if (done_cnt !== d0 + 1 || addr_ptr !== 9'd0) begin bad++; $display("FAIL tp0_done: got done=%0d ptr=%0d want %0d 0", done_cnt, addr_ptr, d0 + 1); end
    triggered = 1'b0;
    start(511);
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL tp511_pre: got %b want 0", armed); end
    wr();
    total++; if (armed !== 1'b1) begin bad++; $display("FAIL tp511_armed: got %b want 1", armed); end
    run = 1'b0;
    tick();
  endtask
  task automatic test_rst_mid_pre();
    int w0;
    start(100);
    repeat (5) wr();
    total++; if (waddr !== 9'd5) begin bad++; $display("FAIL rst_pre_waddr: got %0d want 5", waddr); end
    rst = 1'b1;
    tick();
    total++; if ({we, armed, set_capture_done, capturing, waddr, addr_ptr} !== '0) begin bad++; $display("FAIL rst_mid_pre: got %h want 0", {we, armed, set_capture_done, capturing, waddr, addr_ptr}); end
    rst = 1'b0;
    tick();
    repeat (3) wr();
    total++; if (waddr !== 9'd3) begin bad++; $display("FAIL rst_wrt_pre: got %0d want 3", waddr); end
    w0 = we_cnt;
    rst = 1'b1;
    wrt_smpl = 1'b1;
    #1;
    total++; if (we !== 1'b0) begin bad++; $display("FAIL rst_wrt_we: got %b want 0", we); end
    tick();
    total++; if (waddr !== 9'd0 || we_cnt !== w0) begin bad++; $display("FAIL rst_wrt_nowrite: got waddr=%0d we=%0d want 0 %0d", waddr, we_cnt, w0); end
    rst = 1'b0;
    wrt_smpl = 1'b0;
    run = 1'b0;
    tick();
  endtask
  task automatic test_trig_held();
    int n, d0;
    triggered = 1'b1;
    start(383);
    tick();
    total++; if (armed !== 1'b0 || capturing !== 1'b1) begin bad++; $display("FAIL held_pre: got armed=%b cap=%b want 0 1", armed, capturing); end
    wrt_smpl = 1'b1;
    tick();
    wrt_smpl = 1'b0;
    total++; if (armed !== 1'b1) begin bad++; $display("FAIL held_armed: got %b want 1", armed); end
    tick();
    total++; if (armed !== 1'b0 || capturing !== 1'b1) begin bad++; $display("FAIL held_post: got armed=%b cap=%b want 0 1", armed, capturing); end
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      wr();
      n++;
    end
    total++; if (n !== 383 || addr_ptr !== 9'd0) begin bad++; $display("FAIL held_done: got writes=%0d ptr=%0d want 383 0", n, addr_ptr); end
    run = 1'b0;
    triggered = 1'b0;
    tick();
  endtask
  initial begin
    test_reset();
    test_pre_arm();
    test_post();
    test_wrap();
    test_abort();
    test_boundary();
    test_rst_mid_pre();
    test_trig_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
